// File: rtl/demux1_4_reg.sv
// Registered 1-to-4 demux with valid/ready and one holding register per channel.
// Optional per-channel drain counters are enabled by DEMUX_CNT_EN.
module demux1_4_reg #(
    parameter int BIT_WIDTH = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [BIT_WIDTH-1:0] out0_data,
    output logic [BIT_WIDTH-1:0] out1_data,
    output logic [BIT_WIDTH-1:0] out2_data,
    output logic [BIT_WIDTH-1:0] out3_data,
`ifdef DEMUX_CNT_EN
    output logic [CNT_WIDTH-1:0] xfer_cnt0,
    output logic [CNT_WIDTH-1:0] xfer_cnt1,
    output logic [CNT_WIDTH-1:0] xfer_cnt2,
    output logic [CNT_WIDTH-1:0] xfer_cnt3,
`endif
    output logic                 busy
);

    logic [3:0]           full_q, full_d;
    logic [3:0]           acc, drn;
    logic [BIT_WIDTH-1:0] data_q [4];

    assign in_ready = !full_q[sel] | out_ready[sel];

    always_comb begin
        acc    = '0;
        drn    = full_q & out_ready;
        full_d = full_q;
        for (int k = 0; k < 4; k++) begin
            acc[k]    = in_valid & in_ready & (sel == 2'(k));
            full_d[k] = acc[k] | (full_q[k] & !drn[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
            for (int k = 0; k < 4; k++) data_q[k] <= '0;
        end else begin
            full_q <= full_d;
            for (int k = 0; k < 4; k++)
                if (acc[k]) data_q[k] <= in_data;
        end
    end

    assign out_valid = full_q;
    assign busy      = |full_q;
    assign out0_data = data_q[0];
    assign out1_data = data_q[1];
    assign out2_data = data_q[2];
    assign out3_data = data_q[3];

`ifdef DEMUX_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q [4];

    // Counters wrap naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (drn[k]) cnt_q[k] <= cnt_q[k] + CNT_WIDTH'(1);
        end
    end

    assign xfer_cnt0 = cnt_q[0];
    assign xfer_cnt1 = cnt_q[1];
    assign xfer_cnt2 = cnt_q[2];
    assign xfer_cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux1_4_reg.sv
// Directed self-checking bench for demux1_4_reg.
// Counter checks run when DEMUX_CNT_EN is defined (CNT_WIDTH=4).
module tb_demux1_4_reg;

    localparam int BW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    sel;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [BW-1:0] out0_data, out1_data, out2_data, out3_data;
    logic          busy;
`ifdef DEMUX_CNT_EN
    logic [CW-1:0] xfer_cnt0, xfer_cnt1, xfer_cnt2, xfer_cnt3;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    demux1_4_reg #(.BIT_WIDTH(BW), .CNT_WIDTH(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sel(sel),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out0_data(out0_data),
        .out1_data(out1_data),
        .out2_data(out2_data),
        .out3_data(out3_data),
`ifdef DEMUX_CNT_EN
        .xfer_cnt0(xfer_cnt0),
        .xfer_cnt1(xfer_cnt1),
        .xfer_cnt2(xfer_cnt2),
        .xfer_cnt3(xfer_cnt3),
`endif
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        sel = 2'd0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 4'b0000;
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_d0", 64'(out0_data), 64'h0);
        chk("rst_d3", 64'(out3_data), 64'h0);
        rst_n = 1'b1;
        tick();

        // Routing
        sel = 2'd2; in_data = 32'hDEADBEEF; in_valid = 1'b1;
        out_ready = 4'b1111;
        #1 chk("rt_rdy", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        chk("rt_valid", 64'(out_valid), 64'h4);
        chk("rt_d2", 64'(out2_data), 64'hDEADBEEF);
        chk("rt_busy", 64'(busy), 64'h1);
        tick();
        chk("rt_empty", 64'(out_valid), 64'h0);
        chk("rt_busy0", 64'(busy), 64'h0);

        // Backpressure isolation
        out_ready = 4'b1110;
        sel = 2'd0; in_data = 32'h11; in_valid = 1'b1;
        #1 chk("bp_rdy11", 64'(in_ready), 64'h1);
        tick();
        chk("bp_v0", 64'(out_valid), 64'h1);
        chk("bp_d0_11", 64'(out0_data), 64'h11);
        in_data = 32'h22;
        #1 chk("bp_rdy22", 64'(in_ready), 64'h0);
        tick();
        chk("bp_hold", 64'(out0_data), 64'h11);
        sel = 2'd1; in_data = 32'h33;
        #1 chk("bp_rdy33", 64'(in_ready), 64'h1);
        tick();
        chk("bp_d1", 64'(out1_data), 64'h33);
        chk("bp_v01", 64'(out_valid), 64'h3);
        chk("bp_d0_keep", 64'(out0_data), 64'h11);
        sel = 2'd0; in_data = 32'h22; out_ready = 4'b1111;
        #1 chk("bp_rdy_rel", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        chk("bp_d0_22", 64'(out0_data), 64'h22);
        chk("bp_v_22", 64'(out_valid), 64'h1);
        tick();
        chk("bp_drained", 64'(out_valid), 64'h0);

        // Full throughput on channel 3
        sel = 2'd3; out_ready = 4'b1111;
        for (int i = 1; i <= 8; i++) begin
            in_data = 32'(i); in_valid = 1'b1;
            #1 chk("tp_rdy", 64'(in_ready), 64'h1);
            if (i > 1) begin
                chk("tp_d3", 64'(out3_data), 64'(i - 1));
                chk("tp_v3", 64'(out_valid), 64'h8);
            end
            tick();
        end
        in_valid = 1'b0;
        chk("tp_last", 64'(out3_data), 64'h8);
        tick();
        chk("tp_empty", 64'(out_valid), 64'h0);

        // All channels full, no consumer ready
        out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k); in_data = 32'hA0 + 32'(k); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            #1 chk("af_rdy", 64'(in_ready), 64'h0);
        end
        chk("af_busy", 64'(busy), 64'h1);
        chk("af_valid", 64'(out_valid), 64'hF);
        chk("af_d2", 64'(out2_data), 64'hA2);
        out_ready = 4'b1111;
        tick();
        chk("af_rel_v", 64'(out_valid), 64'h0);
        chk("af_rel_b", 64'(busy), 64'h0);

        // Asynchronous reset mid-stream
        out_ready = 4'b0000;
        sel = 2'd1; in_data = 32'h55; in_valid = 1'b1;
        tick();
        sel = 2'd3; in_data = 32'h77;
        tick();
        in_valid = 1'b0;
        chk("ar_pre", 64'(out_valid), 64'hA);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'h0);
        chk("ar_busy", 64'(busy), 64'h0);
        chk("ar_d1", 64'(out1_data), 64'h0);
        chk("ar_d3", 64'(out3_data), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

`ifdef DEMUX_CNT_EN
        out_ready = 4'b1111;
        sel = 2'd1;
        for (int i = 0; i < 17; i++) begin
            in_data = 32'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("cnt1_wrap", 64'(xfer_cnt1), 64'h1);
        chk("cnt0", 64'(xfer_cnt0), 64'h0);
        chk("cnt2", 64'(xfer_cnt2), 64'h0);
        chk("cnt3", 64'(xfer_cnt3), 64'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/demux1_4_reg.md
Name: demux1_4_reg

Overview:
- Registered 1-to-4 demultiplexer with valid/ready handshake; the inverse-direction companion to the 4:1 select mux.
- Routes one producer stream to one of four consumer channels chosen by `sel`.
- Each channel has a one-entry holding register, so a stalled consumer blocks only its own channel.
- Sits between a single datapath source (e.g. writeback/result bus) and up to four independent sinks.

Parameters:
- BIT_WIDTH, 32, width of data path.
- CNT_WIDTH, 16, width of per-channel transfer counters (used only with DEMUX_CNT_EN).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sel  input  2  destination channel for current input beat (0..3).
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept beat for channel `sel` this cycle.
- in_data  input  BIT_WIDTH  input payload.
- out_valid  output  4  bit k: channel k holds a beat.
- out_ready  input  4  bit k: consumer k accepts this cycle.
- out0_data..out3_data  output  BIT_WIDTH each  channel 0..3 payload.
- busy  output  1  OR of all out_valid bits.
- xfer_cnt0..xfer_cnt3  output  CNT_WIDTH each  present only with DEMUX_CNT_EN.

Behaviour:
- Reset (rst_n low, asynchronous, any cycle including mid-transfer):
  - out_valid = 4'b0000; outK_data = 0; busy = 0; counters = 0.
  - Held beats are discarded.
- Per channel k, state: full[k]. out_valid[k] = full[k] (registered, no combinational path from in_valid).
- in_ready = !full[sel] | out_ready[sel]. Combinational on sel, full, out_ready; independent of in_valid.
- Accept: in_valid & in_ready at a rising edge.
  - Loads in_data into channel sel register and sets full[sel].
  - Latency: beat visible on outK_data/out_valid[k] the cycle after acceptance (1 cycle).
- Drain: out_valid[k] & out_ready[k] at a rising edge clears full[k], unless the same edge also accepts into k.
- Simultaneous accept and drain, same channel: new data loaded, full[k] stays 1 (full throughput, one beat per cycle per channel).
- Accept into channel j while channel k≠j drains: both occur independently.
- Stall: full[sel] & !out_ready[sel] makes in_ready = 0. Producer must hold sel, in_data and in_valid stable until acceptance.
- Other channels' holding registers are never touched by an accept for sel.
- While out_valid[k] & !out_ready[k], outK_data is stable.
- After a drain with no refill, outK_data keeps its last value (don't-care to consumer).
- Only one input beat per cycle; at most four beats buffered in total.
- busy = |full, registered-derived.

Optional Feature:
- Macro DEMUX_CNT_EN.
- Defined:
  - xfer_cnt0..3 ports exist. xfer_cntK increments by 1 on each drain handshake of channel k.
  - Wraps from 2^CNT_WIDTH-1 to 0.
  - Reset to 0 asynchronously.
  - Simultaneous accept+drain counts one.
- Undefined: counter ports and logic absent; all other behaviour identical.

Test Plan:
- Reset mid-stream: channels 1 and 3 full, assert rst_n=0 between edges.
  - Required: out_valid=0000, busy=0, out1_data=out3_data=0 immediately, without waiting for a clock edge.
- Routing: sel=2, in_data=0xDEADBEEF, in_valid=1, out_ready=1111.
  - Required: next cycle out_valid=0100 and out2_data=0xDEADBEEF.
  - Next cycle with in_valid=0: out_valid=0000.
- Backpressure isolation: out_ready[0]=0.
  - Send 0x11 to channel 0: accepted.
  - Send 0x22 to channel 0: in_ready=0, held.
  - Send 0x33 to channel 1 meanwhile: accepted, out1_data=0x33.
  - Raise out_ready[0]: 0x11 drains, 0x22 accepted the same edge; next cycle out0_data=0x22.
- Full throughput: sel=3, out_ready[3]=1, in_valid=1 for 8 cycles, data 1..8.
  - Required: in_ready constantly 1; out3_data sequence 1..8 on consecutive cycles, no drop or duplicate.
- All channels full, all out_ready=0.
  - Required: in_ready=0 for every sel, busy=1.
  - Release out_ready=1111: out_valid=0000 one edge later, busy=0.
- With DEMUX_CNT_EN, CNT_WIDTH=4: drain 17 beats on channel 1.
  - Required: xfer_cnt1=1 (wrapped at 16); other counters 0.
